// File: rtl/reg_file_pkg.sv
// Shared CPU constants and the register-array type passed between the
// register file and its read-port selectors.
package reg_file_pkg;

  localparam int REG_W  = 32;
  localparam int REG_N  = 32;
  localparam int ADDR_W = 5;

  typedef logic [REG_W-1:0]  word_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef word_t [REG_N-1:0] regs_t;

endpackage

// File: rtl/reg_rd_port.sv
// One combinational read selector over the whole register array; the
// register file uses three copies (two CPU read ports and the debug port).
module reg_rd_port
  import reg_file_pkg::*;
(
  input  regs_t i_regs,
  input  addr_t i_addr,
  output word_t o_data
);

  assign o_data = i_regs[i_addr];

endmodule

// File: rtl/reg_file.sv
// 32x32 register file with two forwarding-capable read ports and a
// button-driven debug scan pointer for inspecting registers on a board.
module reg_file
  import reg_file_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic  clk,
  input  logic  clr,
  input  logic  we,
  input  addr_t wa,
  input  word_t wd,
  input  addr_t ra1,
  input  addr_t ra2,
  output word_t rd1,
  output word_t rd2,
  input  logic  dbg_en,
  input  logic  dbg_step,
  output addr_t dbg_addr,
  output word_t dbg_data
);

  regs_t r_regs;
  logic  r_stepQ;
  addr_t r_dbgAddr;
  word_t w_rd1Stored;
  word_t w_rd2Stored;
  logic  w_fwd1;
  logic  w_fwd2;
  logic  w_stepEvent;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_regs <= '0;
    end else if (we && (wa != '0)) begin
      r_regs[wa] <= wd;
    end
  end

  assign w_stepEvent = dbg_step && !r_stepQ;

  // Edge-detecting the step level means a held button advances only once;
  // step_q tracks the level even while disabled, so those steps are dropped.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_stepQ   <= 1'b0;
      r_dbgAddr <= '0;
    end else begin
      r_stepQ <= dbg_step;
      if (dbg_en && w_stepEvent) begin
        r_dbgAddr <= addr_t'(r_dbgAddr + 1'b1);
      end
    end
  end

  reg_rd_port u_rdPort1 (.i_regs(r_regs), .i_addr(ra1),       .o_data(w_rd1Stored));
  reg_rd_port u_rdPort2 (.i_regs(r_regs), .i_addr(ra2),       .o_data(w_rd2Stored));
  reg_rd_port u_rdPortD (.i_regs(r_regs), .i_addr(r_dbgAddr), .o_data(dbg_data));

  assign w_fwd1 = BYPASS && we && (wa == ra1) && (wa != '0);
  assign w_fwd2 = BYPASS && we && (wa == ra2) && (wa != '0);

  assign rd1      = w_fwd1 ? wd : w_rd1Stored;
  assign rd2      = w_fwd2 ? wd : w_rd2Stored;
  assign dbg_addr = r_dbgAddr;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: a forwarding and a non-forwarding instance share the
// same stimulus; directed vectors, debug-scan sequences, then random traffic.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic        dbg_en = 1'b0;
  logic        dbg_step = 1'b0;
  logic [31:0] rd1Byp, rd2Byp, rd1Nob, rd2Nob;
  logic [31:0] dbgDataByp, dbgDataNob;
  logic [4:0]  dbgAddrByp, dbgAddrNob;

  int nCompared = 0;
  int nMismatched = 0;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] expRd1Byp;
    logic [31:0] expRd2Byp;
    logic [31:0] expRd1Nob;
    logic [31:0] expRd2Nob;
  } vec_t;

  vec_t vecs [8];

  logic [31:0] model [32];
  int          mDbgAddr;
  logic        mStepQ;

  reg_file #(.BYPASS(1'b1)) u_byp (
    .clk(clk), .clr(clr), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
    .rd1(rd1Byp), .rd2(rd2Byp), .dbg_en(dbg_en), .dbg_step(dbg_step),
    .dbg_addr(dbgAddrByp), .dbg_data(dbgDataByp)
  );

  reg_file #(.BYPASS(1'b0)) u_nob (
    .clk(clk), .clr(clr), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
    .rd1(rd1Nob), .rd2(rd2Nob), .dbg_en(dbg_en), .dbg_step(dbg_step),
    .dbg_addr(dbgAddrNob), .dbg_data(dbgDataNob)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    we  = v.we;
    wa  = v.wa;
    wd  = v.wd;
    ra1 = v.ra1;
    ra2 = v.ra2;
  endtask

  task automatic doReset();
    @(negedge clk);
    we = 1'b0; dbg_en = 1'b0; dbg_step = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    #2;
    clr = 1'b0;
  endtask

  task automatic stepPulse();
    @(posedge clk); #1; dbg_step = 1'b1;
    @(posedge clk); #1; dbg_step = 1'b0;
  endtask

  task automatic checkDbgAddr(input string name, input int exp);
    @(negedge clk);
    checkOutput({name, "_byp"}, 32'(dbgAddrByp), 32'(exp));
    checkOutput({name, "_nob"}, 32'(dbgAddrNob), 32'(exp));
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 5'd0, 32'h12345678, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[4] = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'h0};
    vecs[5] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[6] = '{1'b1, 5'd7, 32'h00000001, 5'd7, 5'd7, 32'h1, 32'h1, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[7] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 32'h1, 32'hDEADBEEF, 32'h1, 32'hDEADBEEF};

    // Reset state: every address reads zero on every port.
    doReset();
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      checkOutput("rst_rd1", rd1Byp, 32'h0);
      checkOutput("rst_rd2", rd2Nob, 32'h0);
    end
    checkOutput("rst_dbg_data", dbgDataByp, 32'h0);
    checkOutput("rst_dbg_addr", 32'(dbgAddrByp), 32'h0);

    // Directed vectors: basic write/read, r0 write discard, forwarding.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_rd1_byp", i), rd1Byp, vecs[i].expRd1Byp);
      checkOutput($sformatf("vec%0d_rd2_byp", i), rd2Byp, vecs[i].expRd2Byp);
      checkOutput($sformatf("vec%0d_rd1_nob", i), rd1Nob, vecs[i].expRd1Nob);
      checkOutput($sformatf("vec%0d_rd2_nob", i), rd2Nob, vecs[i].expRd2Nob);
    end

    // Held step advances once; 32 pulses wrap through 31 back to 0.
    doReset();
    dbg_en = 1'b1;
    @(posedge clk); #1; dbg_step = 1'b1;
    repeat (10) @(posedge clk);
    #1; dbg_step = 1'b0;
    checkDbgAddr("hold_step", 1);
    doReset();
    dbg_en = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      stepPulse();
      if (i == 31) checkDbgAddr("pulse31", 31);
    end
    checkDbgAddr("pulse32_wrap", 0);

    // Steps while disabled are lost, including one still held at enable.
    stepPulse();
    checkDbgAddr("en_step", 1);
    @(posedge clk); #1; dbg_en = 1'b0;
    stepPulse();
    checkDbgAddr("dis_step", 1);
    @(posedge clk); #1; dbg_step = 1'b1;
    @(posedge clk); #1; dbg_en = 1'b1;
    repeat (3) @(posedge clk);
    #1; dbg_step = 1'b0;
    checkDbgAddr("held_across_enable", 1);

    // Debug port shows a write to the displayed register only after the edge.
    doReset();
    @(posedge clk); #1; we = 1'b1; wa = 5'd3; wd = 32'h55;
    @(posedge clk); #1; we = 1'b0;
    dbg_en = 1'b1;
    repeat (3) stepPulse();
    checkDbgAddr("dbg_at3", 3);
    checkOutput("dbg_r3_old", dbgDataByp, 32'h55);
    @(posedge clk); #1; we = 1'b1; wa = 5'd3; wd = 32'h66;
    @(negedge clk);
    checkOutput("dbg_before_edge", dbgDataByp, 32'h55);
    @(posedge clk); #1;
    we = 1'b0;
    checkOutput("dbg_after_edge", dbgDataByp, 32'h66);
    checkOutput("dbg_after_edge_nob", dbgDataNob, 32'h66);

    // Mid-cycle clear beats a coincident write and clears everything at once.
    @(posedge clk); #1; we = 1'b1; wa = 5'd5; wd = 32'hFFFF0000; ra1 = 5'd3; ra2 = 5'd3;
    @(negedge clk);
    clr = 1'b1;
    #1;
    checkOutput("clr_rd1", rd1Byp, 32'h0);
    checkOutput("clr_rd2_nob", rd2Nob, 32'h0);
    checkOutput("clr_dbg_data", dbgDataByp, 32'h0);
    checkOutput("clr_dbg_addr", 32'(dbgAddrByp), 32'h0);
    @(posedge clk); #2;
    clr = 1'b0; we = 1'b0; ra1 = 5'd5;
    #1;
    checkOutput("clr_write_lost", rd1Byp, 32'h0);
    checkOutput("clr_write_lost_nob", rd1Nob, 32'h0);

    // Random traffic against an array model of the register contents.
    doReset();
    foreach (model[i]) model[i] = 32'h0;
    mDbgAddr = 0;
    mStepQ = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic [31:0] e1, e2;
      @(posedge clk); #1;
      we  = 1'($urandom_range(0, 1));
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      dbg_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) dbg_step = ~dbg_step;
      @(negedge clk);
      e1 = (we && wa == ra1 && wa != 0) ? wd : model[ra1];
      e2 = (we && wa == ra2 && wa != 0) ? wd : model[ra2];
      checkOutput("rnd_rd1_byp", rd1Byp, e1);
      checkOutput("rnd_rd2_byp", rd2Byp, e2);
      checkOutput("rnd_rd1_nob", rd1Nob, model[ra1]);
      checkOutput("rnd_rd2_nob", rd2Nob, model[ra2]);
      checkOutput("rnd_dbg_addr", 32'(dbgAddrByp), 32'(mDbgAddr));
      checkOutput("rnd_dbg_data", dbgDataNob, model[mDbgAddr]);
      if (we && wa != 0) model[wa] = wd;
      if (dbg_en && dbg_step && !mStepQ) mDbgAddr = (mDbgAddr + 1) % 32;
      mStepQ = dbg_step;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
